// File: rtl/alarm_zone_ctrl_pkg.sv
// Shared types and constants for the alarm zone controller.
package alarm_zone_ctrl_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ENTRY    = 2'd2,
        ALARM    = 2'd3
    } state_t;

    localparam int                     ALARM_CNT_W   = 8;
    localparam logic [ALARM_CNT_W-1:0] ALARM_CNT_MAX = 8'd255;

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter; expired is high during the last counted cycle.
module alarm_timer
    import alarm_zone_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign busy    = (count != '0);
    assign expired = (count == W'(1));

endmodule

// File: rtl/alarm_zone_ctrl.sv
// N-zone alarm controller: arm/disarm FSM, entry delay, timed siren, zone history, event counter.
// Optional box-tamper input enabled by defining ALARM_ZONE_CTRL_TAMPER_EN.
module alarm_zone_ctrl
    import alarm_zone_ctrl_pkg::*;
#(
    parameter int                 N_ZONES      = 4,
    parameter logic [N_ZONES-1:0] ENTRY_ZONES  = 4'b0001,
    parameter int                 ENTRY_DELAY  = 8,
    parameter int                 SIREN_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   disarm,
    input  logic [N_ZONES-1:0]     zone,
    input  logic [N_ZONES-1:0]     zone_mask,
`ifdef ALARM_ZONE_CTRL_TAMPER_EN
    input  logic                   tamper,
`endif
    output logic                   armed,
    output logic                   entry_pending,
    output logic                   siren,
    output logic                   arm_fail,
    output logic [N_ZONES-1:0]     latched_zones,
    output logic [ALARM_CNT_W-1:0] alarm_count
);

    localparam int EW = $clog2(ENTRY_DELAY + 1);
    localparam int SW = $clog2(SIREN_CYCLES + 1);

    state_t             state;
    state_t             next_state;
    logic [N_ZONES-1:0] act;
    logic [N_ZONES-1:0] ent;
    logic [N_ZONES-1:0] ins;
    logic               tamper_hit;
    logic               arm_reject;
    logic               entry_load;
    logic               entry_busy;
    logic               entry_expired;
    logic               siren_load;
    logic               siren_busy;
    logic               siren_expired;

    assign act = zone & ~zone_mask;
    assign ent = act & ENTRY_ZONES;
    assign ins = act & ~ENTRY_ZONES;

`ifdef ALARM_ZONE_CTRL_TAMPER_EN
    assign tamper_hit = tamper;
`else
    assign tamper_hit = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        arm_reject = 1'b0;
        case (state)
            DISARMED: begin
                if (arm && !disarm) begin
                    if (act == '0) next_state = ARMED;
                    else           arm_reject = 1'b1;
                end
            end
            ARMED: begin
                if (disarm)          next_state = DISARMED;
                else if (ins != '0)  next_state = ALARM;
                else if (ent != '0)  next_state = ENTRY;
            end
            ENTRY: begin
                if (disarm)                            next_state = DISARMED;
                else if (ins != '0)                    next_state = ALARM;
                else if (entry_expired || !entry_busy) next_state = ALARM;
            end
            ALARM: begin
                if (disarm) next_state = DISARMED;
            end
            default: next_state = DISARMED;
        endcase
        // Tamper overrides everything except reset, including disarm.
        if (tamper_hit) begin
            next_state = ALARM;
            arm_reject = 1'b0;
        end
    end

    assign entry_load = (state != ENTRY) && (next_state == ENTRY);
    assign siren_load = (state != ALARM) && (next_state == ALARM);

    alarm_timer #(.W(EW)) u_entry_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (entry_load),
        .load_val (EW'(ENTRY_DELAY)),
        .busy     (entry_busy),
        .expired  (entry_expired)
    );

    alarm_timer #(.W(SW)) u_siren_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (siren_load),
        .load_val (SW'(SIREN_CYCLES)),
        .busy     (siren_busy),
        .expired  (siren_expired)
    );

    // NOTE: reset is synchronous; all state here is plain flops, no memories, so all of it is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= DISARMED;
            armed         <= 1'b0;
            entry_pending <= 1'b0;
            siren         <= 1'b0;
            arm_fail      <= 1'b0;
            latched_zones <= '0;
            alarm_count   <= '0;
        end else begin
            state         <= next_state;
            armed         <= (next_state != DISARMED);
            entry_pending <= (next_state == ENTRY);
            arm_fail      <= arm_reject;
            // A retrigger inside ALARM never reloads the timer, so siren just runs out.
            siren         <= (next_state == ALARM) &&
                             (siren_load || (siren_busy && !siren_expired));
            if (state == DISARMED && next_state == ARMED) begin
                latched_zones <= '0;
            end else if (state != DISARMED) begin
                latched_zones <= latched_zones | act;
            end
            if (siren_load && alarm_count != ALARM_CNT_MAX) begin
                alarm_count <= alarm_count + ALARM_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Directed self-checking bench for alarm_zone_ctrl with default parameters.
// Covers tamper behaviour when ALARM_ZONE_CTRL_TAMPER_EN is defined.
module tb_alarm_zone_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm;
    logic       disarm;
    logic [3:0] zone;
    logic [3:0] zone_mask;
`ifdef ALARM_ZONE_CTRL_TAMPER_EN
    logic       tamper;
`endif
    logic       armed;
    logic       entry_pending;
    logic       siren;
    logic       arm_fail;
    logic [3:0] latched_zones;
    logic [7:0] alarm_count;

    int total  = 0;
    int passed = 0;
    int n;

    always #5 clk = ~clk;

    alarm_zone_ctrl #(
        .N_ZONES      (4),
        .ENTRY_ZONES  (4'b0001),
        .ENTRY_DELAY  (8),
        .SIREN_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .disarm        (disarm),
        .zone          (zone),
        .zone_mask     (zone_mask),
`ifdef ALARM_ZONE_CTRL_TAMPER_EN
        .tamper        (tamper),
`endif
        .armed         (armed),
        .entry_pending (entry_pending),
        .siren         (siren),
        .arm_fail      (arm_fail),
        .latched_zones (latched_zones),
        .alarm_count   (alarm_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; disarm = 1'b0; zone = '0; zone_mask = '0;
`ifdef ALARM_ZONE_CTRL_TAMPER_EN
        tamper = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        check("reset_armed",   32'(armed), 0);
        check("reset_entry",   32'(entry_pending), 0);
        check("reset_siren",   32'(siren), 0);
        check("reset_armfail", 32'(arm_fail), 0);
        check("reset_latched", 32'(latched_zones), 0);
        check("reset_count",   32'(alarm_count), 0);

        // Arm rejected with an active instant zone, then accepted once it is masked.
        arm = 1'b1; zone = 4'b0100;
        tick();
        check("armfail_pulse", 32'(arm_fail), 1);
        check("armfail_armed", 32'(armed), 0);
        arm = 1'b0;
        tick();
        check("armfail_single", 32'(arm_fail), 0);
        zone_mask = 4'b0100; arm = 1'b1;
        tick();
        check("arm_masked_armed", 32'(armed), 1);
        check("arm_masked_nofail", 32'(arm_fail), 0);
        arm = 1'b0; zone = '0; zone_mask = '0;
        tick();
        check("armed_latched_empty", 32'(latched_zones), 0);

        // Entry zone, disarm on the 5th ENTRY cycle.
        zone = 4'b0001;
        tick();
        zone = '0;
        n = 1;
        while (n < 5 && entry_pending) begin
            tick();
            if (entry_pending) n++;
        end
        check("entry_cycles_before_disarm", 32'(n), 5);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        check("entry_disarm_armed", 32'(armed), 0);
        check("entry_disarm_pending", 32'(entry_pending), 0);
        check("entry_disarm_siren", 32'(siren), 0);
        tick(); tick();
        check("entry_disarm_siren_later", 32'(siren), 0);
        check("entry_disarm_count", 32'(alarm_count), 0);
        check("entry_disarm_latched", 32'(latched_zones), 4'b0001);

        // Entry zone, no disarm: full delay then timed siren.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("rearm_latched_cleared", 32'(latched_zones), 0);
        zone = 4'b0001;
        tick();
        zone = '0;
        n = 0;
        while (entry_pending && siren == 1'b0 && n < 100) begin
            n++;
            tick();
        end
        check("entry_length", 32'(n), 8);
        check("siren_after_entry", 32'(siren), 1);
        check("count_after_entry_alarm", 32'(alarm_count), 1);
        n = 0;
        while (siren && n < 100) begin
            n++;
            tick();
        end
        check("siren_length", 32'(n), 16);
        check("alarm_persists_armed", 32'(armed), 1);
        check("entry_latched", 32'(latched_zones), 4'b0001);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        check("disarm_from_alarm", 32'(armed), 0);

        // Instant zone, disarm during siren.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        zone = 4'b1000;
        tick();
        zone = '0;
        check("instant_siren", 32'(siren), 1);
        check("instant_count", 32'(alarm_count), 2);
        tick(); tick(); tick();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        check("instant_disarm_siren", 32'(siren), 0);
        check("instant_disarm_armed", 32'(armed), 0);
        check("instant_latched_held", 32'(latched_zones), 4'b1000);

        // Simultaneous arm and disarm with an active zone: nothing happens.
        arm = 1'b1; disarm = 1'b1; zone = 4'b0100;
        tick();
        check("arm_disarm_armed", 32'(armed), 0);
        check("arm_disarm_nofail", 32'(arm_fail), 0);
        arm = 1'b0; disarm = 1'b0; zone = '0;

        // Reset mid-siren.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        zone = 4'b1000;
        tick();
        zone = '0;
        check("pre_rst_siren", 32'(siren), 1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_siren_all", {armed, entry_pending, siren, arm_fail, latched_zones, alarm_count}, 0);

        // Saturation of the event counter.
        for (int i = 0; i < 256; i++) begin
            arm = 1'b1;
            tick();
            arm = 1'b0;
            zone = 4'b1000;
            tick();
            zone = '0;
            if (i == 127) check("count_mid", 32'(alarm_count), 128);
            disarm = 1'b1;
            tick();
            disarm = 1'b0;
        end
        check("count_saturated", 32'(alarm_count), 255);

`ifdef ALARM_ZONE_CTRL_TAMPER_EN
        tamper = 1'b1;
        tick();
        check("tamper_siren", 32'(siren), 1);
        check("tamper_armed", 32'(armed), 1);
        disarm = 1'b1;
        tick();
        check("tamper_beats_disarm", 32'(armed), 1);
        tamper = 1'b0;
        tick();
        disarm = 1'b0;
        check("tamper_release_disarm", 32'(armed), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alarm_zone_ctrl.md
# alarm_zone_ctrl

Sequential, parametrised alarm controller for N sensor zones. It replaces purely combinational sensor-to-alarm decoding with the following features:
- arm/disarm control
- per-zone masking
- an entry-delay path for designated entry zones
- a time-limited siren
- latched zone history
- a saturating alarm-event counter

It sits between the synchronised sensor inputs and the siren/indicator drivers.

## Interface
Parameters:
- N_ZONES, 4, number of sensor zones (1..16)
- ENTRY_ZONES, 4'b0001, N_ZONES-bit mask; set bits are entry zones that start the entry delay instead of an immediate alarm
- ENTRY_DELAY, 8, entry-delay length in cycles (≥1)
- SIREN_CYCLES, 16, siren-on duration in cycles (≥1)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- arm  in  1  request to arm (level, sampled each cycle)
- disarm  in  1  request to disarm (level, sampled each cycle)
- zone  in  N_ZONES  sensor inputs, 1 = triggered
- zone_mask  in  N_ZONES  1 = zone bypassed (ignored)
- armed  out  1  state is ARMED, ENTRY or ALARM
- entry_pending  out  1  state is ENTRY
- siren  out  1  siren drive
- arm_fail  out  1  one-cycle pulse: arm rejected
- latched_zones  out  N_ZONES  zones that triggered while armed
- alarm_count  out  8  saturating count of alarm events

## Operation
- Active zones: act = zone & ~zone_mask. Entry hits: ent = act & ENTRY_ZONES. Instant hits: ins = act & ~ENTRY_ZONES.
- FSM states: DISARMED, ARMED, ENTRY, ALARM. Reset state is DISARMED.
- DISARMED:
  - arm & ~disarm & act==0 → ARMED.
  - arm & ~disarm & act!=0 → stay in DISARMED and pulse arm_fail for 1 cycle.
- ARMED:
  - disarm → DISARMED.
  - otherwise ins!=0 → ALARM.
  - otherwise ent!=0 → ENTRY, loading the entry timer.
- ENTRY:
  - disarm → DISARMED.
  - otherwise ins!=0 → ALARM immediately.
  - otherwise the timer expires → ALARM.
- ALARM:
  - Siren timer loaded on entry to the state.
  - State persists after the siren expires; only disarm → DISARMED.
- Priority: rst > disarm > ins > timer expiry > ent. When arm and disarm are asserted together, disarm wins and no arm_fail is issued.
- latched_zones:
  - ORs in act every cycle while in ARMED, ENTRY or ALARM, and holds its value.
  - Cleared on the DISARMED→ARMED transition and on rst.
  - Preserved through disarm so it can be read out.
- alarm_count: +1 on every transition into ALARM; saturates at 255; cleared only by rst.
- A retrigger while in ALARM does not reload the siren timer.

## Timing
- All outputs are registered and change only on a clk rising edge.
- Reset values: armed=0, entry_pending=0, siren=0, arm_fail=0, latched_zones=0, alarm_count=0.
- Input sampled at edge k → new state, and outputs reflecting it, valid after edge k.
- ENTRY lasts exactly ENTRY_DELAY cycles. entry_pending is high ENTRY_DELAY cycles, then siren rises on the next edge if no disarm arrives.
- disarm seen on the last ENTRY cycle still wins; no alarm occurs.
- siren is high for exactly SIREN_CYCLES cycles, starting at the first ALARM cycle.
- rst asserted in any state (mid-ENTRY, mid-siren) returns to DISARMED on that edge. All outputs take reset values after that edge.

## Configuration
- Macro: ALARM_ZONE_CTRL_TAMPER_EN.
- Defined:
  - Adds port tamper (in, 1), a box-tamper sensor that ignores zone_mask and the armed state.
  - tamper=1 in any state, including DISARMED → ALARM next edge, loading the siren timer and incrementing alarm_count.
  - tamper takes priority over disarm. While tamper is held, the state stays in ALARM.
- Undefined: no tamper port, no tamper logic; behaviour exactly as above.

## Structure
- Package alarm_zone_ctrl_pkg:
  - state typedef (DISARMED=2'd0, ARMED=2'd1, ENTRY=2'd2, ALARM=2'd3)
  - ALARM_CNT_W=8
  - ALARM_CNT_MAX=255
- Sub-module alarm_timer: loadable down-counter with inputs load and load_val, and outputs busy and expired.
  - Instance 1: entry delay.
  - Instance 2: siren duration.
- Top level: FSM, latched-zone register and event counter.

## Test plan
Defaults for all scenarios: N_ZONES=4, ENTRY_ZONES=4'b0001, ENTRY_DELAY=8, SIREN_CYCLES=16.
- Arm with zone=4'b0100, mask=0 → arm_fail 1-cycle pulse, armed stays 0. Repeat with mask=4'b0100 → armed=1 next edge.
- Armed, zone=4'b0001 for 1 cycle, then disarm on the 5th ENTRY cycle → entry_pending high 5 cycles, siren never rises, alarm_count=0.
- Armed, zone=4'b0001, no disarm → entry_pending 8 cycles, siren high exactly 16 cycles, armed stays 1, alarm_count=1, latched_zones=4'b0001.
- Armed, zone=4'b1000 → siren next edge. Disarm during siren → siren=0 and armed=0 next edge, latched_zones=4'b1000 held.
- Simultaneous arm and disarm while DISARMED → no state change, no arm_fail. rst mid-siren → all outputs 0 next edge.
- 256 alarm/disarm cycles → alarm_count saturates at 255. With ALARM_ZONE_CTRL_TAMPER_EN defined: tamper=1 while DISARMED → siren next edge.
